// File: rtl/sc_matmul_engine.sv
// Stochastic-computing matrix multiplier: output(m,o) ~ sum over ramp cycles of x(m,k)>r AND w(o,k)>bitrev(r).
// Optional `SC_MM_ABORT_EN adds an abort input that cancels RUN/DONE back to IDLE.
module sc_matmul_engine #(
  parameter int BATCH_SIZE        = 4,
  parameter int INPUT_FEATURES    = 4,
  parameter int OUTPUT_FEATURES   = 4,
  parameter int BINARY_PRECISION  = 8,
  parameter int STOCHASTIC_CYCLES = 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 start,
`ifdef SC_MM_ABORT_EN
  input  logic                                                 abort,
`endif
  input  logic [BINARY_PRECISION*BATCH_SIZE*INPUT_FEATURES-1:0]  input_matrix,
  input  logic [BINARY_PRECISION*OUTPUT_FEATURES*INPUT_FEATURES-1:0] weight_matrix,
  input  logic                                                 outputReady,
  output logic                                                 busy,
  output logic [BINARY_PRECISION*BATCH_SIZE*OUTPUT_FEATURES-1:0] output_matrix,
  output logic                                                 outputWrEn
);
  localparam int M    = BATCH_SIZE;
  localparam int N    = INPUT_FEATURES;
  localparam int O    = OUTPUT_FEATURES;
  localparam int P    = BINARY_PRECISION;
  localparam int LOGN = $clog2(N);
  localparam int LOGS = $clog2(STOCHASTIC_CYCLES);
  localparam int CW   = P + LOGS;
  localparam int AW   = P + LOGS + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       c_q, c_d;
  logic [P*M*N-1:0]    x_q, x_d;
  logic [P*O*N-1:0]    w_q, w_d;
  logic [P*M*O-1:0]    out_q, out_d;
  logic [AW-1:0]       acc_q [M][O];
  logic [AW-1:0]       acc_d [M][O];

  logic [P-1:0]        r, r_rev;
  logic [LOGN-1:0]     k;
  logic [AW-1:0]       quot;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    x_d     = x_q;
    w_d     = w_q;
    out_d   = out_q;
    acc_d   = acc_q;
    quot    = '0;
    r       = c_q[P-1:0];
    k       = c_q[LOGN-1:0];
    for (int unsigned i = 0; i < P; i++) r_rev[i] = r[P-1-i];

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = input_matrix;
          w_d     = weight_matrix;
          c_d     = '0;
          for (int unsigned m = 0; m < M; m++)
            for (int unsigned o = 0; o < O; o++) acc_d[m][o] = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        c_d = c_q + CW'(1);
        for (int unsigned m = 0; m < M; m++)
          for (int unsigned o = 0; o < O; o++)
            if ((x_q[(m*N+k)*P +: P] > r) && (w_q[(o*N+k)*P +: P] > r_rev))
              acc_d[m][o] = acc_q[m][o] + AW'(1);
        if (c_q == '1) begin
          state_d = DONE;
          // Result is taken from acc_d so the final cycle's bit is counted.
          for (int unsigned m = 0; m < M; m++)
            for (int unsigned o = 0; o < O; o++) begin
              quot = acc_d[m][o] >> LOGS;
              out_d[(m*O+o)*P +: P] = (quot[AW-1:P] != '0) ? '1 : quot[P-1:0];
            end
        end
      end
      DONE: begin
        if (outputReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SC_MM_ABORT_EN
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      out_d   = out_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      x_q     <= '0;
      w_q     <= '0;
      out_q   <= '0;
      for (int unsigned m = 0; m < M; m++)
        for (int unsigned o = 0; o < O; o++) acc_q[m][o] <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      x_q     <= x_d;
      w_q     <= w_d;
      out_q   <= out_d;
      acc_q   <= acc_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign outputWrEn    = (state_q == DONE);
  assign output_matrix = out_q;
endmodule

// File: tb/tb_sc_matmul_engine.sv
// Scoreboard bench for sc_matmul_engine at default parameters; exercises abort when SC_MM_ABORT_EN is defined.
module tb_sc_matmul_engine;
  localparam int M  = 4;
  localparam int N  = 4;
  localparam int O  = 4;
  localparam int P  = 8;
  localparam int S  = 1;
  localparam int L  = S * (1 << P);
  localparam int XW = P*M*N;
  localparam int WW = P*O*N;
  localparam int OW = P*M*O;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          output_ready = 1'b0;
  logic [XW-1:0] input_matrix = '0;
  logic [WW-1:0] weight_matrix = '0;
  logic          busy;
  logic [OW-1:0] output_matrix;
  logic          output_wr_en;
`ifdef SC_MM_ABORT_EN
  logic          abort = 1'b0;
`endif

  int unsigned   total = 0;
  int unsigned   bad = 0;
  logic [OW-1:0] sb [$];
  logic [OW-1:0] last_out = '0;

  sc_matmul_engine #(
    .BATCH_SIZE(M), .INPUT_FEATURES(N), .OUTPUT_FEATURES(O),
    .BINARY_PRECISION(P), .STOCHASTIC_CYCLES(S)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SC_MM_ABORT_EN
    .abort(abort),
`endif
    .input_matrix(input_matrix), .weight_matrix(weight_matrix),
    .outputReady(output_ready), .busy(busy),
    .output_matrix(output_matrix), .outputWrEn(output_wr_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] model(input logic [XW-1:0] xv, input logic [WW-1:0] wv);
    logic [OW-1:0] res;
    logic [P-1:0]  r, rr, xe, we;
    int unsigned   cnt, q;
    res = '0;
    for (int m = 0; m < M; m++)
      for (int o = 0; o < O; o++) begin
        cnt = 0;
        for (int c = 0; c < L; c++) begin
          r = P'(c % (1 << P));
          for (int i = 0; i < P; i++) rr[i] = r[P-1-i];
          xe = xv[(m*N + (c % N))*P +: P];
          we = wv[(o*N + (c % N))*P +: P];
          if (xe > r && we > rr) cnt++;
        end
        q = cnt / S;
        if (q >= (1 << P)) q = (1 << P) - 1;
        res[(m*O+o)*P +: P] = P'(q);
      end
    return res;
  endfunction

  function automatic logic [XW-1:0] fill_x(input logic [P-1:0] v);
    logic [XW-1:0] t;
    for (int i = 0; i < M*N; i++) t[i*P +: P] = v;
    return t;
  endfunction

  function automatic logic [WW-1:0] fill_w(input logic [P-1:0] v);
    logic [WW-1:0] t;
    for (int i = 0; i < O*N; i++) t[i*P +: P] = v;
    return t;
  endfunction

  // Start a run; returns after the start-sampling posedge.
  task automatic launch(input logic [XW-1:0] xv, input logic [WW-1:0] wv, input bit expect_out);
    @(negedge clk);
    input_matrix  = xv;
    weight_matrix = wv;
    start         = 1'b1;
    if (expect_out) sb.push_back(model(xv, wv));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait for outputWrEn; checks latency and scoreboard value, leaves bench at that negedge.
  task automatic wait_result(input string tag);
    int cyc;
    logic [OW-1:0] exp;
    cyc = 0;
    while (cyc < 2*L) begin
      @(negedge clk);
      cyc++;
      if (output_wr_en) break;
    end
    check({tag, "_latency"}, OW'(cyc), OW'(L+1));
    check({tag, "_sb_nonempty"}, OW'(sb.size() != 0), OW'(1));
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      check({tag, "_out"}, output_matrix, exp);
      last_out = exp;
    end
  endtask

  task automatic accept(input string tag);
    output_ready = 1'b1;
    @(posedge clk);
    #1 output_ready = 1'b0;
    check({tag, "_busy_after_ready"}, OW'(busy), OW'(0));
    check({tag, "_wren_after_ready"}, OW'(output_wr_en), OW'(0));
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (output_wr_en) seen++;
    end
    check({tag, "_no_wren"}, OW'(seen), OW'(0));
  endtask

  initial begin
    logic [XW-1:0] xv;
    logic [WW-1:0] wv;
    logic [OW-1:0] held;
    int            cyc;

    #12;
    check("rst_busy", OW'(busy), OW'(0));
    check("rst_wren", OW'(output_wr_en), OW'(0));
    check("rst_out", output_matrix, '0);
    @(negedge clk);
    rst = 1'b0;

    launch(fill_x(8'd255), fill_w(8'd255), 1'b1);
    wait_result("all255");
    check("all255_const", output_matrix, {(M*O){8'd255}});
    accept("all255");

    launch(fill_x(8'd128), fill_w(8'd255), 1'b1);
    wait_result("x128");
    check("x128_const", output_matrix, {(M*O){8'd128}});
    accept("x128");

    xv = '0;
    for (int m = 0; m < M; m++) xv[(m*N)*P +: P] = 8'd255;
    launch(xv, fill_w(8'd255), 1'b1);
    wait_result("col0");
    check("col0_const", output_matrix, {(M*O){8'd64}});
    accept("col0");

    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < M*N; i++) xv[i*P +: P] = P'($urandom_range(0, 255));
      for (int i = 0; i < O*N; i++) wv[i*P +: P] = P'($urandom_range(0, 255));
      launch(xv, wv, 1'b1);
      wait_result("rand");
      accept("rand");
    end

    // Hold in DONE with changing inputs; output and outputWrEn must not move.
    launch(fill_x(8'd200), fill_w(8'd100), 1'b1);
    wait_result("hold");
    held = output_matrix;
    for (int i = 0; i < 20; i++) begin
      input_matrix  = fill_x(P'($urandom_range(0, 255)));
      weight_matrix = fill_w(P'($urandom_range(0, 255)));
      @(negedge clk);
      check("hold_out", output_matrix, last_out);
      check("hold_wren", OW'(output_wr_en), OW'(1));
    end
    // start together with ready in DONE: returns to IDLE only.
    start = 1'b1;
    accept("hold");
    start = 1'b0;
    @(negedge clk);
    check("hold_start_ignored", OW'(busy), OW'(0));
    check("hold_out_kept", output_matrix, held);

    // Asynchronous reset at c=100.
    launch(fill_x(8'd255), fill_w(8'd255), 1'b0);
    cyc = 0;
    while (cyc < 101) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_busy", OW'(busy), OW'(1));
    #2 rst = 1'b1;
    #1;
    check("rstmid_out", output_matrix, '0);
    check("rstmid_busy", OW'(busy), OW'(0));
    check("rstmid_wren", OW'(output_wr_en), OW'(0));
    @(negedge clk);
    rst = 1'b0;
    expect_quiet("rstmid", L + 20);
    launch('0, fill_w(8'd255), 1'b1);
    wait_result("zero");
    check("zero_const", output_matrix, '0);
    accept("zero");

`ifdef SC_MM_ABORT_EN
    launch(fill_x(8'd77), fill_w(8'd255), 1'b1);
    wait_result("pre_abort");
    accept("pre_abort");
    held = output_matrix;
    launch(fill_x(8'd255), fill_w(8'd255), 1'b0);
    cyc = 0;
    while (cyc < 51) begin
      @(negedge clk);
      cyc++;
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", OW'(busy), OW'(0));
    check("abort_out", output_matrix, held);
    expect_quiet("abort", L + 20);
    check("abort_out_later", output_matrix, held);
`endif

    check("sb_drained", OW'(sb.size()), OW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
